// File: rtl/nand_decoder_event_counter_pkg.sv
// Shared constants and decode helpers for the NAND decoder event monitor.
package nand_decoder_event_counter_pkg;

   localparam int         NUM_CH        = 4;
   localparam logic [3:0] IDLE_PATTERN  = 4'b1111;
   localparam int         CNT_W_DEFAULT = 8;

   localparam logic [1:0] CH0 = 2'd0;
   localparam logic [1:0] CH1 = 2'd1;
   localparam logic [1:0] CH2 = 2'd2;
   localparam logic [1:0] CH3 = 2'd3;

   function automatic logic one_low(input logic [3:0] v);
      return (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
   endfunction

   // Only meaningful when one_low(v) holds.
   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = CH0;
      case (v)
         4'b1101: idx = CH1;
         4'b1011: idx = CH2;
         4'b0111: idx = CH3;
         default: idx = CH0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/nand_decoder_event_counter_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; rst > clr > inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX = '1;

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != MAX)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/nand_decoder_event_counter.sv
// Registers active-low decoder lines, re-encodes the low line, flags illegal patterns
// and tallies per-channel assertion edges; outputs update one edge after the sample.
module nand_decoder_event_counter
   import nand_decoder_event_counter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d0,
   input  logic             d1,
   input  logic             d2,
   input  logic             d3,
   input  logic             clr,
   input  logic [1:0]       rd_sel,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [1:0]       code,
   output logic             code_valid,
   output logic             illegal,
   output logic             err
);

   logic [3:0]        d_q;
   logic [3:0]        d_prev;
   logic              legal;
   logic [NUM_CH-1:0] event_hit;
   logic [CNT_W-1:0]  cnt [NUM_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q        <= IDLE_PATTERN;
         d_prev     <= IDLE_PATTERN;
         code       <= '0;
         code_valid <= 1'b0;
         illegal    <= 1'b0;
         err        <= 1'b0;
      end else begin
         d_q     <= {d3, d2, d1, d0};
         d_prev  <= d_q;
         illegal <= !legal;
         if (legal) begin
            code       <= low_index(d_q);
            code_valid <= 1'b1;
         end else begin
            code_valid <= 1'b0;
         end
         if (clr) begin
            err <= 1'b0;
         end else if (!legal) begin
            err <= 1'b1;
         end
      end
   end

   // A line counts only on its high-to-low transition within a legal sample.
   always_comb begin
      legal     = one_low(d_q);
      event_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         event_hit[i] = legal && !d_q[i] && d_prev[i];
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      sat_counter #(
         .W(CNT_W)
      ) u_cnt (
         .clk(clk),
         .rst(rst),
         .clr(clr),
         .inc(event_hit[i]),
         .q  (cnt[i])
      );
   end

   assign rd_cnt = cnt[rd_sel];

endmodule
